siren_tone_sequencer: RTL and testbench

- Sits directly downstream of police_siren.
- Consumes its two tone square waves (clk_out1 = tone A, clk_out2 = tone B) and sequences them into one speaker drive signal.
- Produces a hi-lo wail (alternating A/B) or a steady single tone, with glitch-free switching and a programmable silent gap between segments.
- Also drives two indicator LEDs and a segment-start strobe.

---
 rtl/siren_tone_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_siren_tone_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siren_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : siren_tone_sequencer
//  Description : Sequences the two police_siren tone square waves into one
//                speaker drive. It supports hi-lo wail and steady-tone modes,
//                switches without truncating a high pulse, and can insert a
//                silent gap between segments. It also drives two tone LEDs
//                and a segment-start strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module siren_tone_sequencer #(
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES   = 5000000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       tone_a_in,
    input  logic       tone_b_in,
    output logic       spk_out,
    output logic       led_a,
    output logic       led_b,
    output logic       phase_tick
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_play  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_gap   = 2'd3;

    localparam logic [1:0] c_mode_a   = 2'b01;
    localparam logic [1:0] c_mode_alt = 2'b10;
    localparam logic [1:0] c_mode_b   = 2'b11;

    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last   =
        CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic             c_gap_en     = (GAP_CYCLES > 0);

    // Tone select encoding: 0 = tone A, 1 = tone B.
    logic             r_tone_a;
    logic             r_tone_b;
    logic [1:0]       r_state;
    logic             r_sel;
    logic             r_next_sel;
    logic             r_drain_off;
    logic [CNT_W-1:0] r_cnt;
    logic             r_spk;
    logic             r_led_a;
    logic             r_led_b;
    logic             r_tick;

    logic             w_tone_sel;
    logic             w_want_sel;
    logic             w_want_off;
    logic [1:0]       w_state_nx;
    logic             w_sel_nx;
    logic             w_next_sel_nx;
    logic             w_drain_off_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_spk_nx;
    logic             w_tick_nx;
    logic             w_active_nx;

    assign w_tone_sel  = r_sel ? r_tone_b : r_tone_a;
    assign w_active_nx = (w_state_nx == c_st_play) || (w_state_nx == c_st_drain);

    // Decode which tone the mode asks for at the next dwell expiry.
    always_comb begin
        w_want_sel = r_sel;
        w_want_off = 1'b0;
        case (mode)
            c_mode_a:   w_want_sel = 1'b0;
            c_mode_b:   w_want_sel = 1'b1;
            c_mode_alt: w_want_sel = ~r_sel;
            default:    w_want_off = 1'b1;
        endcase
    end

    // Next-state, counter and registered-output values for the sequencer.
    always_comb begin
        w_state_nx     = r_state;
        w_sel_nx       = r_sel;
        w_next_sel_nx  = r_next_sel;
        w_drain_off_nx = r_drain_off;
        w_cnt_nx       = r_cnt;
        w_spk_nx       = 1'b0;
        w_tick_nx      = 1'b0;

        if (!en) begin
            // Abrupt cut: no drain when the enable drops.
            w_state_nx = c_st_idle;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (mode != 2'b00) begin
                        w_state_nx = c_st_play;
                        w_sel_nx   = (mode == c_mode_b);
                        w_cnt_nx   = '0;
                        w_tick_nx  = 1'b1;
                    end
                end
                c_st_play: begin
                    w_spk_nx = w_tone_sel;
                    if (r_cnt == c_dwell_last) begin
                        if (!w_want_off && (w_want_sel == r_sel)) begin
                            // Same tone again: restart seamlessly.
                            w_cnt_nx  = '0;
                            w_tick_nx = 1'b1;
                        end else begin
                            w_state_nx     = c_st_drain;
                            w_next_sel_nx  = w_want_sel;
                            w_drain_off_nx = w_want_off;
                            w_cnt_nx       = '0;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                c_st_drain: begin
                    // Keep following the tone until its high pulse completes.
                    w_spk_nx = w_tone_sel;
                    if (!w_tone_sel) begin
                        w_cnt_nx = '0;
                        if (r_drain_off) begin
                            w_state_nx = c_st_idle;
                        end else if (!c_gap_en) begin
                            w_state_nx = c_st_play;
                            w_sel_nx   = r_next_sel;
                            w_tick_nx  = 1'b1;
                        end else begin
                            w_state_nx = c_st_gap;
                        end
                    end
                end
                default: begin
                    if (r_cnt == c_gap_last) begin
                        w_state_nx = c_st_play;
                        w_sel_nx   = r_next_sel;
                        w_cnt_nx   = '0;
                        w_tick_nx  = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Single register stage on the tone inputs (same clock domain).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tone_a <= 1'b0;
            r_tone_b <= 1'b0;
        end else begin
            r_tone_a <= tone_a_in;
            r_tone_b <= tone_b_in;
        end
    end

    // State register plus registered outputs; reset aborts any segment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_sel       <= 1'b0;
            r_next_sel  <= 1'b0;
            r_drain_off <= 1'b0;
            r_cnt       <= '0;
            r_spk       <= 1'b0;
            r_led_a     <= 1'b0;
            r_led_b     <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_sel       <= w_sel_nx;
            r_next_sel  <= w_next_sel_nx;
            r_drain_off <= w_drain_off_nx;
            r_cnt       <= w_cnt_nx;
            r_spk       <= w_spk_nx;
            r_led_a     <= w_active_nx & ~w_sel_nx;
            r_led_b     <= w_active_nx & w_sel_nx;
            r_tick      <= w_tick_nx;
        end
    end

    assign spk_out    = r_spk;
    assign led_a      = r_led_a;
    assign led_b      = r_led_b;
    assign phase_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_siren_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_siren_tone_sequencer
//  Description : Self-checking bench for siren_tone_sequencer. Two instances
//                (gap of 2 cycles and no gap) share the stimulus; a segment
//                level reference model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_siren_tone_sequencer;

    localparam int c_dwell = 8;
    localparam int c_gap0  = 2;
    localparam int c_gap1  = 0;

    localparam int c_ph_idle  = 0;
    localparam int c_ph_play  = 1;
    localparam int c_ph_drain = 2;
    localparam int c_ph_gap   = 3;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       en     = 1'b0;
    logic [1:0] mode   = 2'b00;
    logic       tone_a = 1'b0;
    logic       tone_b = 1'b0;
    logic       stuck_a = 1'b0;
    logic       stuck_b = 1'b0;

    logic [1:0] spk_w;
    logic [1:0] led_a_w;
    logic [1:0] led_b_w;
    logic [1:0] tick_w;

    int n_total = 0;
    int n_pass  = 0;

    siren_tone_sequencer #(
        .DWELL_CYCLES (c_dwell),
        .GAP_CYCLES   (c_gap0),
        .CNT_W        (8)
    ) u_dut_gap (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .tone_a_in  (tone_a),
        .tone_b_in  (tone_b),
        .spk_out    (spk_w[0]),
        .led_a      (led_a_w[0]),
        .led_b      (led_b_w[0]),
        .phase_tick (tick_w[0])
    );

    siren_tone_sequencer #(
        .DWELL_CYCLES (c_dwell),
        .GAP_CYCLES   (c_gap1),
        .CNT_W        (8)
    ) u_dut_nogap (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .tone_a_in  (tone_a),
        .tone_b_in  (tone_b),
        .spk_out    (spk_w[1]),
        .led_a      (led_a_w[1]),
        .led_b      (led_b_w[1]),
        .phase_tick (tick_w[1])
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Tone sources: A toggles every 2 clocks, B every 3; either can be stuck high.
    int unsigned cyc = 0;
    always @(negedge clk) begin
        cyc    = cyc + 1;
        tone_a = stuck_a | (((cyc / 2) % 2) == 1);
        tone_b = stuck_b | (((cyc / 3) % 2) == 1);
    end

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h, expected %0h at %0t",
                      name, k, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: segment view with countdown of remaining cycles.
    // ------------------------------------------------------------------
    int   m_phase [2];
    int   m_left  [2];
    int   m_segb  [2];
    int   m_next  [2];   // -1 means the sequencer turns off after draining
    logic m_ta_r = 1'b0;
    logic m_tb_r = 1'b0;
    logic e_spk  [2];
    logic e_la   [2];
    logic e_lb   [2];
    logic e_tick [2];
    logic ta_hist[2];

    function automatic int gap_of(input int k);
        return (k == 0) ? c_gap0 : c_gap1;
    endfunction

    // Tone requested at dwell expiry: 0 = A, 1 = B, -1 = off.
    function automatic int tone_after_expiry(input logic [1:0] md, input int cur_b);
        case (md)
            2'b01:   return 0;
            2'b11:   return 1;
            2'b10:   return 1 - cur_b;
            default: return -1;
        endcase
    endfunction

    task automatic start_seg(input int k, input int b);
        m_phase[k] = c_ph_play;
        m_segb[k]  = b;
        m_left[k]  = c_dwell;
        e_tick[k]  = 1'b1;
    endtask

    task automatic model_step(input int k);
        logic cur;
        int   want;
        cur       = (m_segb[k] != 0) ? m_tb_r : m_ta_r;
        e_spk[k]  = 1'b0;
        e_tick[k] = 1'b0;
        if (rst) begin
            m_phase[k] = c_ph_idle;
            m_segb[k]  = 0;
        end else if (!en) begin
            m_phase[k] = c_ph_idle;
        end else begin
            case (m_phase[k])
                c_ph_idle: if (mode != 2'b00) start_seg(k, (mode == 2'b11) ? 1 : 0);
                c_ph_play: begin
                    e_spk[k]  = cur;
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        want = tone_after_expiry(mode, m_segb[k]);
                        if (want == m_segb[k]) start_seg(k, want);
                        else begin
                            m_phase[k] = c_ph_drain;
                            m_next[k]  = want;
                        end
                    end
                end
                c_ph_drain: begin
                    e_spk[k] = cur;
                    if (!cur) begin
                        if (m_next[k] < 0)        m_phase[k] = c_ph_idle;
                        else if (gap_of(k) == 0)  start_seg(k, m_next[k]);
                        else begin
                            m_phase[k] = c_ph_gap;
                            m_left[k]  = gap_of(k);
                        end
                    end
                end
                default: begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) start_seg(k, m_next[k]);
                end
            endcase
        end
        e_la[k] = (m_phase[k] == c_ph_play || m_phase[k] == c_ph_drain) && (m_segb[k] == 0);
        e_lb[k] = (m_phase[k] == c_ph_play || m_phase[k] == c_ph_drain) && (m_segb[k] != 0);
    endtask

    // Advance the model on each edge, then compare all outputs of both DUTs.
    always @(posedge clk) begin
        ta_hist[1] = ta_hist[0];
        ta_hist[0] = tone_a;
        for (int k = 0; k < 2; k++) model_step(k);
        m_ta_r = rst ? 1'b0 : tone_a;
        m_tb_r = rst ? 1'b0 : tone_b;
        #2;
        for (int j = 0; j < 2; j++) begin
            check("spk_out",    j, spk_w[j],   e_spk[j]);
            check("led_a",      j, led_a_w[j], e_la[j]);
            check("led_b",      j, led_b_w[j], e_lb[j]);
            check("phase_tick", j, tick_w[j],  e_tick[j]);
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Called in the first cycle of an A segment that must be followed by B.
    task automatic measure_ab(input int k);
        int la;
        int gl;
        int guard;
        la = 0; gl = 0; guard = 0;
        while (led_a_w[k] === 1'b1 && guard < 60) begin
            check("a_seg_led_b_low", k, led_b_w[k], 1'b0);
            la++; guard++;
            step();
        end
        while (led_a_w[k] !== 1'b1 && led_b_w[k] !== 1'b1 && guard < 60) begin
            check("gap_spk_low", k, spk_w[k], 1'b0);
            gl++; guard++;
            step();
        end
        check("a_len_min", k, la >= 9,  1'b1);
        check("a_len_max", k, la <= 11, 1'b1);
        check("gap_len",   k, gl, gap_of(k));
        check("b_led",     k, led_b_w[k], 1'b1);
        check("b_tick",    k, tick_w[k],  1'b1);
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int guard;
        int nt[2];

        repeat (3) @(negedge clk);
        step();
        for (int k = 0; k < 2; k++) begin
            check("rst_spk",   k, spk_w[k],   1'b0);
            check("rst_led_a", k, led_a_w[k], 1'b0);
            check("rst_led_b", k, led_b_w[k], 1'b0);
            check("rst_tick",  k, tick_w[k],  1'b0);
        end

        // Alternate A/B from reset.
        @(negedge clk);
        en = 1'b1; mode = 2'b10; rst = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            check("start_tick",  k, tick_w[k],  1'b1);
            check("start_led_a", k, led_a_w[k], 1'b1);
        end
        fork
            measure_ab(0);
            measure_ab(1);
        join

        // Reset in the middle of a PLAY segment with the speaker high.
        guard = 0;
        while (!(spk_w[0] === 1'b1 && m_phase[0] == c_ph_play) && guard < 40) begin
            step();
            guard++;
        end
        check("wait_spk_high", 0, guard < 40, 1'b1);
        @(negedge clk); rst = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            check("midrst_spk",   k, spk_w[k],   1'b0);
            check("midrst_led_a", k, led_a_w[k], 1'b0);
            check("midrst_led_b", k, led_b_w[k], 1'b0);
        end
        @(negedge clk); rst = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            check("resume_tick",  k, tick_w[k],  1'b1);
            check("resume_led_a", k, led_a_w[k], 1'b1);
            check("resume_led_b", k, led_b_w[k], 1'b0);
        end

        // Steady A: speaker is tone A delayed two edges, tick every 8 cycles.
        @(negedge clk); rst = 1'b1; mode = 2'b01;
        @(negedge clk); rst = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            check("steady_first_tick", k, tick_w[k], 1'b1);
            nt[k] = 0;
        end
        repeat (24) begin
            step();
            for (int k = 0; k < 2; k++) begin
                check("steady_spk",   k, spk_w[k],   ta_hist[1]);
                check("steady_led_b", k, led_b_w[k], 1'b0);
                nt[k] += int'(tick_w[k]);
            end
        end
        for (int k = 0; k < 2; k++) check("steady_ticks", k, nt[k], 3);

        // Mode change early in an A segment takes effect only at expiry.
        fork
            measure_ab(0);
            measure_ab(1);
            begin
                repeat (2) step();
                @(negedge clk); mode = 2'b11;
            end
        join

        // Enable drop during PLAY cuts everything at the next edge.
        @(negedge clk); en = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            check("endrop_spk",   k, spk_w[k],   1'b0);
            check("endrop_led_a", k, led_a_w[k], 1'b0);
            check("endrop_led_b", k, led_b_w[k], 1'b0);
        end
        @(negedge clk); en = 1'b1;

        // Randomized traffic, checked cycle by cycle against the model.
        repeat (2500) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) stuck_a = ~stuck_a;
            if ($urandom_range(0, 99) == 0) stuck_b = ~stuck_b;
        end
        stuck_a = 1'b0;
        stuck_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
